wb_copy_master: RTL and testbench
=================================

WB_COPY_MASTER -- requirements
Module: wb_copy_master

Interface
REQ-001 SHALL have parameter CHUNK_P2, default 2, meaning log2 of the internal word-buffer depth and of the maximum words per read/write burst (4 words).
REQ-002 SHALL have parameter LEN_W, default 16, meaning the width of the word-count field.
REQ-003 SHALL have the following ports, one per line (name, direction, width, meaning):
- CLK  in  1  single clock; all logic on rising edge.
- RST_ASYNC_N  in  1  asynchronous active-low reset.
- CMD_VALID_IN  in  1  copy request valid.
- CMD_READY_OUT  out  1  block idle and able to accept a command.
- CMD_SRC_ADR_IN  in  32  source byte address, word aligned.
- CMD_DST_ADR_IN  in  32  destination byte address, word aligned.
- CMD_LEN_IN  in  LEN_W  number of 32-bit words to copy.
- DONE_OUT  out  1  one-cycle pulse when a command completes or aborts.
- ERR_OUT  out  1  sticky; set on WB error; cleared on accepting the next command.
- WB_ADR_OUT  out  32  Wishbone address.
- WB_CYC_OUT  out  1  cycle.
- WB_STB_OUT  out  1  strobe.
- WB_WE_OUT  out  1  write enable.
- WB_SEL_OUT  out  4  byte selects, always 4'b1111 while STB is high.
- WB_CTI_OUT  out  3  cycle type.
- WB_BTE_OUT  out  2  burst type, always 2'b00.
- WB_STALL_IN  in  1  slave stall (pipelined Wishbone B4).
- WB_ACK_IN  in  1  slave acknowledge.
- WB_ERR_IN  in  1  slave error.
- WB_DAT_RD_IN  in  32  read data.
- WB_DAT_WR_OUT  out  32  write data.

Function
REQ-004 SHALL accept a command on the cycle where CMD_VALID_IN and CMD_READY_OUT are both high; CMD_READY_OUT SHALL be high only in IDLE.
REQ-005 A command with CMD_LEN_IN=0 SHALL produce DONE_OUT on the next cycle, SHALL NOT start a bus cycle, and SHALL clear ERR_OUT.
REQ-006 FSM states: IDLE, RD (issue reads), RD_WAIT (drain acks), WR (issue writes), WR_WAIT (drain acks), FIN.
- IDLE -> RD on accept.
- RD -> RD_WAIT when the last read of the chunk is issued.
- RD_WAIT -> WR when all chunk acks are received.
- WR -> WR_WAIT when the last write of the chunk is issued.
- WR_WAIT -> RD if words remain, else FIN.
- FIN -> IDLE after one cycle, with DONE_OUT pulsed.
REQ-007 Chunk size SHALL be min(remaining, 2^CHUNK_P2).
REQ-008 A request SHALL be issued when STB is high and STALL is low; address SHALL advance by 4 per issued request; STB SHALL hold ADR and DAT stable while stalled.
REQ-009 CYC SHALL assert with the first STB of a chunk and deassert the cycle after the final ACK of that chunk; there SHALL be at least one idle cycle (CYC low) between the read and write phases.
REQ-010 Outstanding requests SHALL be counted as issued minus acked; a phase SHALL NOT end while the count is nonzero; a same-cycle issue and ACK SHALL leave the count unchanged.
REQ-011 Read data SHALL be written into the buffer in ACK order; writes SHALL present buffer entries in the same order.
REQ-012 On WB_ERR_IN during CYC: ERR_OUT SHALL set, STB SHALL drop the same cycle, CYC SHALL drop the next cycle, the FSM SHALL go to FIN, and the remaining words SHALL be discarded.
REQ-013 Address wrap SHALL be modulo 2^32 with no error.

Reset
REQ-014 Reset asserted SHALL immediately force IDLE, CMD_READY_OUT=1, DONE_OUT=0, ERR_OUT=0, CYC/STB/WE=0, ADR/DAT_WR=0, CTI=3'b000, outstanding count=0.
REQ-015 Reset mid-transfer SHALL abandon the transfer with no DONE pulse.

Configuration
REQ-016 Macro WB_COPY_BURST_CTI_EN:
- Defined: WB_CTI_OUT SHALL be 3'b010 for every request of a chunk except the last, which SHALL be 3'b111.
- Undefined: WB_CTI_OUT SHALL be 3'b000 always.

Structure
REQ-017 FSM state encodings and the CTI constants (CLASSIC 3'b000, INCR 3'b010, EOB 3'b111) SHALL reside in a shared package, wb_defs_pkg.
REQ-018 The word buffer SHALL be a sub-module wb_copy_buf: 2^CHUNK_P2 x 32, with separate write and read pointers and reset on chunk start.

Verification
REQ-019 Bench SHALL use a pipelined WB slave model with random stall and 0-4 cycle ACK latency, and SHALL cover:
- SRC=0x100, DST=0x200, LEN=3, zero latency -> 3 reads at 0x100/104/108, then 3 writes at 0x200/204/208; destination equals source; one DONE pulse; ERR_OUT=0.
- LEN=9 with random stall -> three chunks (4,4,1); all 9 words copied; issued count equals acked count in every phase.
- LEN=0 -> DONE_OUT one cycle after accept; CYC never asserted.
- WB_ERR_IN on the 2nd read of LEN=4 -> ERR_OUT=1, no write cycles, DONE pulse; the next command clears ERR_OUT.
- RST_ASYNC_N low during a write phase -> all outputs at reset values within the same cycle; no DONE pulse.
- WB_COPY_BURST_CTI_EN defined, LEN=4 -> CTI sequence 010,010,010,111 per phase; undefined -> 000 throughout.

Source files
------------

// File: rtl/wb_defs_pkg.sv
// Shared Wishbone copy-engine definitions: FSM state encoding and cycle/burst type constants.
package wb_defs_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD      = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR      = 3'd3,
    ST_WR_WAIT = 3'd4,
    ST_FIN     = 3'd5
  } copy_state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/wb_copy_buf.sv
// Chunk word buffer: 2^AW x 32, filled in ACK order and drained in the same order.
// Pointers return to zero on clr so each chunk starts at entry 0.
module wb_copy_buf #(
  parameter int AW = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        wr_en,
  input  logic [31:0] wr_dat,
  input  logic        rd_adv,
  output logic [31:0] rd_dat
);

  logic [31:0]   mem_q [2**AW];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_en)  wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_adv) rd_ptr_d = rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !clr) mem_q[wr_ptr_q] <= wr_dat;
  end

  assign rd_dat = mem_q[rd_ptr_q];

endmodule

// File: rtl/wb_copy_master.sv
// Pipelined Wishbone B4 memory-to-memory copy engine, moving up to 2^CHUNK_P2 words per read/write chunk.
// Define WB_COPY_BURST_CTI_EN to emit incrementing-burst CTI (010...111); otherwise CTI stays classic.
module wb_copy_master
  import wb_defs_pkg::*;
#(
  parameter int CHUNK_P2 = 2,
  parameter int LEN_W    = 16
) (
  input  logic             CLK,
  input  logic             RST_ASYNC_N,
  input  logic             CMD_VALID_IN,
  output logic             CMD_READY_OUT,
  input  logic [31:0]      CMD_SRC_ADR_IN,
  input  logic [31:0]      CMD_DST_ADR_IN,
  input  logic [LEN_W-1:0] CMD_LEN_IN,
  output logic             DONE_OUT,
  output logic             ERR_OUT,
  output logic [31:0]      WB_ADR_OUT,
  output logic             WB_CYC_OUT,
  output logic             WB_STB_OUT,
  output logic             WB_WE_OUT,
  output logic [3:0]       WB_SEL_OUT,
  output logic [2:0]       WB_CTI_OUT,
  output logic [1:0]       WB_BTE_OUT,
  input  logic             WB_STALL_IN,
  input  logic             WB_ACK_IN,
  input  logic             WB_ERR_IN,
  input  logic [31:0]      WB_DAT_RD_IN,
  output logic [31:0]      WB_DAT_WR_OUT
);

  localparam int               DEPTH   = 1 << CHUNK_P2;
  localparam int               CW      = CHUNK_P2 + 1;
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

  copy_state_e      state_q, state_d;
  logic [31:0]      src_q, src_d, dst_q, dst_d;
  logic [LEN_W-1:0] rem_q, rem_d, rem_next;
  logic [CW-1:0]    chunk_q, chunk_d, iss_q, iss_d, out_q, out_d;
  logic             gap_q, gap_d, err_q, err_d;
  logic             rd_phase, wr_phase, stb_base, cyc, stb, issue, ack, bus_err;
  logic             last_iss, buf_clr;
  logic [31:0]      buf_rd_dat;

  function automatic logic [CW-1:0] chunk_of(input logic [LEN_W-1:0] words);
    return (words > DEPTH_L) ? CW'(DEPTH) : CW'(words);
  endfunction

  // gap_q holds CYC low for one cycle whenever the bus changes direction
  always_comb begin
    rd_phase = (state_q == ST_RD) || (state_q == ST_RD_WAIT);
    wr_phase = (state_q == ST_WR) || (state_q == ST_WR_WAIT);
    stb_base = ((state_q == ST_RD) || (state_q == ST_WR)) && !gap_q;
    cyc      = stb_base || (state_q == ST_RD_WAIT) || (state_q == ST_WR_WAIT);
    stb      = stb_base && !WB_ERR_IN;
    issue    = stb && !WB_STALL_IN;
    ack      = cyc && WB_ACK_IN;
    bus_err  = cyc && WB_ERR_IN;
    last_iss = issue && (iss_q == chunk_q - CW'(1));
  end

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    rem_d    = rem_q;
    chunk_d  = chunk_q;
    iss_d    = iss_q;
    out_d    = out_q;
    gap_d    = 1'b0;
    err_d    = err_q;
    buf_clr  = 1'b0;
    rem_next = rem_q - LEN_W'(chunk_q);

    if (issue && !ack)      out_d = out_q + CW'(1);
    else if (!issue && ack) out_d = out_q - CW'(1);

    if (issue) begin
      iss_d = iss_q + CW'(1);
      if (rd_phase) src_d = src_q + 32'd4;
      else          dst_d = dst_q + 32'd4;
    end

    case (state_q)
      ST_IDLE: begin
        if (CMD_VALID_IN) begin
          err_d   = 1'b0;
          src_d   = CMD_SRC_ADR_IN;
          dst_d   = CMD_DST_ADR_IN;
          rem_d   = CMD_LEN_IN;
          chunk_d = chunk_of(CMD_LEN_IN);
          iss_d   = '0;
          out_d   = '0;
          buf_clr = 1'b1;
          state_d = (CMD_LEN_IN == '0) ? ST_FIN : ST_RD;
        end
      end
      ST_RD: if (last_iss) state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (out_d == '0) begin
          state_d = ST_WR;
          gap_d   = 1'b1;
          iss_d   = '0;
        end
      end
      ST_WR: if (last_iss) state_d = ST_WR_WAIT;
      ST_WR_WAIT: begin
        if (out_d == '0) begin
          iss_d = '0;
          rem_d = rem_next;
          if (rem_next == '0) begin
            state_d = ST_FIN;
          end else begin
            state_d = ST_RD;
            gap_d   = 1'b1;
            buf_clr = 1'b1;
            chunk_d = chunk_of(rem_next);
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // a bus error abandons the rest of the command; outstanding requests are dropped
    if (bus_err) begin
      state_d = ST_FIN;
      err_d   = 1'b1;
      out_d   = '0;
      gap_d   = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
    if (!RST_ASYNC_N) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      chunk_q <= '0;
      iss_q   <= '0;
      out_q   <= '0;
      gap_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      chunk_q <= chunk_d;
      iss_q   <= iss_d;
      out_q   <= out_d;
      gap_q   <= gap_d;
      err_q   <= err_d;
    end
  end

  wb_copy_buf #(.AW(CHUNK_P2)) u_buf (
    .clk    (CLK),
    .rst_n  (RST_ASYNC_N),
    .clr    (buf_clr),
    .wr_en  (ack && rd_phase),
    .wr_dat (WB_DAT_RD_IN),
    .rd_adv (issue && wr_phase),
    .rd_dat (buf_rd_dat)
  );

  assign CMD_READY_OUT = (state_q == ST_IDLE);
  assign DONE_OUT      = (state_q == ST_FIN);
  assign ERR_OUT       = err_q;
  assign WB_ADR_OUT    = wr_phase ? dst_q : src_q;
  assign WB_CYC_OUT    = cyc;
  assign WB_STB_OUT    = stb;
  assign WB_WE_OUT     = cyc && wr_phase;
  assign WB_SEL_OUT    = stb ? 4'b1111 : 4'b0000;
  assign WB_BTE_OUT    = BTE_LINEAR;
  assign WB_DAT_WR_OUT = (stb && wr_phase) ? buf_rd_dat : 32'd0;

`ifdef WB_COPY_BURST_CTI_EN
  assign WB_CTI_OUT = !stb ? CTI_CLASSIC :
                      (iss_q == chunk_q - CW'(1)) ? CTI_EOB : CTI_INCR;
`else
  assign WB_CTI_OUT = CTI_CLASSIC;
`endif

endmodule

// File: tb/tb_wb_copy_master.sv
// Bench for wb_copy_master: pipelined Wishbone slave model with random stall and 0-4 cycle ACK latency.
module tb_wb_copy_master;

  logic        CLK = 1'b0;
  logic        RST_ASYNC_N = 1'b0;
  logic        CMD_VALID_IN = 1'b0;
  logic        CMD_READY_OUT;
  logic [31:0] CMD_SRC_ADR_IN = '0;
  logic [31:0] CMD_DST_ADR_IN = '0;
  logic [15:0] CMD_LEN_IN = '0;
  logic        DONE_OUT, ERR_OUT;
  logic [31:0] WB_ADR_OUT;
  logic        WB_CYC_OUT, WB_STB_OUT, WB_WE_OUT;
  logic [3:0]  WB_SEL_OUT;
  logic [2:0]  WB_CTI_OUT;
  logic [1:0]  WB_BTE_OUT;
  logic        WB_STALL_IN = 1'b0;
  logic        WB_ACK_IN = 1'b0;
  logic        WB_ERR_IN = 1'b0;
  logic [31:0] WB_DAT_RD_IN = '0;
  logic [31:0] WB_DAT_WR_OUT;

  wb_copy_master dut (
    .CLK(CLK), .RST_ASYNC_N(RST_ASYNC_N),
    .CMD_VALID_IN(CMD_VALID_IN), .CMD_READY_OUT(CMD_READY_OUT),
    .CMD_SRC_ADR_IN(CMD_SRC_ADR_IN), .CMD_DST_ADR_IN(CMD_DST_ADR_IN), .CMD_LEN_IN(CMD_LEN_IN),
    .DONE_OUT(DONE_OUT), .ERR_OUT(ERR_OUT),
    .WB_ADR_OUT(WB_ADR_OUT), .WB_CYC_OUT(WB_CYC_OUT), .WB_STB_OUT(WB_STB_OUT), .WB_WE_OUT(WB_WE_OUT),
    .WB_SEL_OUT(WB_SEL_OUT), .WB_CTI_OUT(WB_CTI_OUT), .WB_BTE_OUT(WB_BTE_OUT),
    .WB_STALL_IN(WB_STALL_IN), .WB_ACK_IN(WB_ACK_IN), .WB_ERR_IN(WB_ERR_IN),
    .WB_DAT_RD_IN(WB_DAT_RD_IN), .WB_DAT_WR_OUT(WB_DAT_WR_OUT)
  );

  always #5 CLK = ~CLK;

`ifdef WB_COPY_BURST_CTI_EN
  localparam bit CTI_ON = 1'b1;
`else
  localparam bit CTI_ON = 1'b0;
`endif

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
    int          due;
  } req_t;

  int checks = 0;
  int passes = 0;

  logic [31:0] mem [logic [31:0]];
  req_t        pend [$];
  logic [31:0] log_adr [$];
  logic        log_we [$];
  logic [2:0]  log_cti [$];

  bit stall_en = 1'b0;
  int lat_max  = 0;
  int err_at   = -1;
  int rd_ack_n = 0;
  int cyc_no   = 0;
  int done_cnt = 0;
  int cyc_rise = 0, gap_viol = 0, phase_bad = 0, iss_ph = 0, ack_ph = 0;
  bit cyc_ever = 1'b0, prev_cyc = 1'b0, prev_we = 1'b0;
  bit err_inj = 1'b0;
  logic err_stb = 1'b1, err_cyc_next = 1'b1;

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0;
  endfunction

  function automatic logic [2:0] exp_cti(input int idx, input int n);
    if (!CTI_ON) return 3'b000;
    return (idx == n - 1) ? 3'b111 : 3'b010;
  endfunction

  // Slave drives its outputs on the falling edge, then observes what the DUT will issue on the next rising edge.
  always @(negedge CLK) begin
    req_t r;
    cyc_no++;
    if (err_inj) begin
      err_cyc_next = WB_CYC_OUT;
      err_inj = 1'b0;
    end
    WB_ACK_IN = 1'b0;
    WB_ERR_IN = 1'b0;
    if (!RST_ASYNC_N || !WB_CYC_OUT) pend.delete();
    if (!RST_ASYNC_N) begin
      WB_STALL_IN = 1'b0;
    end else begin
      if (pend.size() > 0 && pend[0].due <= cyc_no) begin
        r = pend.pop_front();
        if (!r.we && rd_ack_n == err_at) begin
          WB_ERR_IN = 1'b1;
          err_inj = 1'b1;
          pend.delete();
        end else begin
          WB_ACK_IN = 1'b1;
          ack_ph++;
          if (r.we) mem[r.adr] = r.dat;
          else WB_DAT_RD_IN = rd_mem(r.adr);
        end
        if (!r.we) rd_ack_n++;
      end
      WB_STALL_IN = stall_en && ($urandom_range(0, 2) == 0);
    end
    #1;
    if (WB_ERR_IN) err_stb = WB_STB_OUT;
    if (WB_CYC_OUT && WB_STB_OUT && !WB_STALL_IN) begin
      r.adr = WB_ADR_OUT;
      r.we  = WB_WE_OUT;
      r.dat = WB_DAT_WR_OUT;
      r.due = cyc_no + 1 + ((lat_max > 0) ? int'($urandom_range(0, lat_max)) : 0);
      pend.push_back(r);
      log_adr.push_back(WB_ADR_OUT);
      log_we.push_back(WB_WE_OUT);
      log_cti.push_back(WB_CTI_OUT);
      iss_ph++;
    end
    if (DONE_OUT) done_cnt++;
    if (WB_CYC_OUT) cyc_ever = 1'b1;
    if (WB_CYC_OUT && !prev_cyc) cyc_rise++;
    if (WB_CYC_OUT && prev_cyc && (WB_WE_OUT != prev_we)) gap_viol++;
    if (!WB_CYC_OUT && prev_cyc) begin
      if (iss_ph != ack_ph) phase_bad++;
      iss_ph = 0;
      ack_ph = 0;
    end
    prev_cyc = WB_CYC_OUT;
    prev_we  = WB_WE_OUT;
  end

  task automatic clear_logs();
    log_adr.delete(); log_we.delete(); log_cti.delete();
    cyc_rise = 0; gap_viol = 0; phase_bad = 0; iss_ph = 0; ack_ph = 0;
    cyc_ever = 1'b0; rd_ack_n = 0; err_at = -1;
  endtask

  task automatic send_cmd(input logic [31:0] s, input logic [31:0] d, input int len);
    int n = 0;
    @(negedge CLK);
    CMD_SRC_ADR_IN = s;
    CMD_DST_ADR_IN = d;
    CMD_LEN_IN     = 16'(len);
    CMD_VALID_IN   = 1'b1;
    while (!CMD_READY_OUT && n < 100) begin
      @(negedge CLK);
      n++;
    end
    @(posedge CLK);
    @(negedge CLK);
    CMD_VALID_IN = 1'b0;
  endtask

  task automatic wait_done(input int d0, output bit ok);
    int n = 0;
    while (done_cnt == d0 && n < 2000) begin
      @(negedge CLK);
      #2;
      n++;
    end
    ok = (done_cnt != d0);
    repeat (4) @(negedge CLK);
    #2;
  endtask

  task automatic test_reset();
    RST_ASYNC_N = 1'b0;
    repeat (3) @(negedge CLK);
    #2;
    checks++; if (CMD_READY_OUT !== 1'b1) $display("FAIL rst_ready: got %b want 1", CMD_READY_OUT); else passes++;
    checks++; if (DONE_OUT !== 1'b0) $display("FAIL rst_done: got %b want 0", DONE_OUT); else passes++;
    checks++; if (ERR_OUT !== 1'b0) $display("FAIL rst_err: got %b want 0", ERR_OUT); else passes++;
    checks++; if ({WB_CYC_OUT, WB_STB_OUT, WB_WE_OUT} !== 3'b000) $display("FAIL rst_cyc_stb_we: got %b want 000", {WB_CYC_OUT, WB_STB_OUT, WB_WE_OUT}); else passes++;
    checks++; if (WB_ADR_OUT !== 32'h0) $display("FAIL rst_adr: got %h want 0", WB_ADR_OUT); else passes++;
    checks++; if (WB_DAT_WR_OUT !== 32'h0) $display("FAIL rst_dat: got %h want 0", WB_DAT_WR_OUT); else passes++;
    checks++; if (WB_CTI_OUT !== 3'b000) $display("FAIL rst_cti: got %b want 000", WB_CTI_OUT); else passes++;
    checks++; if (WB_BTE_OUT !== 2'b00) $display("FAIL rst_bte: got %b want 00", WB_BTE_OUT); else passes++;
    @(negedge CLK);
    RST_ASYNC_N = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_len3();
    logic [31:0] exp_adr [6] = '{32'h100, 32'h104, 32'h108, 32'h200, 32'h204, 32'h208};
    logic [31:0] src [3] = '{32'hA1B2C3D4, 32'h11223344, 32'hCAFEF00D};
    int d0;
    bit ok;
    clear_logs(); stall_en = 1'b0; lat_max = 0;
    for (int i = 0; i < 3; i++) begin
      mem[32'h100 + 32'(4 * i)] = src[i];
      mem[32'h200 + 32'(4 * i)] = 32'h0;
    end
    d0 = done_cnt;
    send_cmd(32'h100, 32'h200, 3);
    wait_done(d0, ok);
    checks++; if (ok !== 1'b1) $display("FAIL len3_done_timeout: no DONE seen"); else passes++;
    checks++; if (log_adr.size() !== 6) $display("FAIL len3_req_count: got %0d want 6", log_adr.size()); else passes++;
    for (int i = 0; i < 6 && i < log_adr.size(); i++) begin
      checks++; if (log_adr[i] !== exp_adr[i]) $display("FAIL len3_adr[%0d]: got %h want %h", i, log_adr[i], exp_adr[i]); else passes++;
      checks++; if (log_we[i] !== (i >= 3)) $display("FAIL len3_we[%0d]: got %b want %b", i, log_we[i], (i >= 3)); else passes++;
      checks++; if (log_cti[i] !== exp_cti(i % 3, 3)) $display("FAIL len3_cti[%0d]: got %b want %b", i, log_cti[i], exp_cti(i % 3, 3)); else passes++;
    end
    for (int i = 0; i < 3; i++) begin
      checks++; if (rd_mem(32'h200 + 32'(4 * i)) !== src[i]) $display("FAIL len3_data[%0d]: got %h want %h", i, rd_mem(32'h200 + 32'(4 * i)), src[i]); else passes++;
    end
    checks++; if (done_cnt - d0 !== 1) $display("FAIL len3_done_pulses: got %0d want 1", done_cnt - d0); else passes++;
    checks++; if (ERR_OUT !== 1'b0) $display("FAIL len3_err: got %b want 0", ERR_OUT); else passes++;
    checks++; if (gap_viol !== 0) $display("FAIL len3_idle_gap: got %0d direction changes without idle, want 0", gap_viol); else passes++;
  endtask

  task automatic test_len9();
    int d0, nrd, nwr;
    bit ok;
    clear_logs(); stall_en = 1'b1; lat_max = 4;
    for (int i = 0; i < 9; i++) begin
      mem[32'h1000 + 32'(4 * i)] = 32'h9000_0000 + 32'(i * 32'h111);
      mem[32'h2000 + 32'(4 * i)] = 32'h0;
    end
    d0 = done_cnt;
    send_cmd(32'h1000, 32'h2000, 9);
    wait_done(d0, ok);
    checks++; if (ok !== 1'b1) $display("FAIL len9_done_timeout: no DONE seen"); else passes++;
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (rd_mem(32'h2000 + 32'(4 * i)) !== 32'h9000_0000 + 32'(i * 32'h111))
        $display("FAIL len9_data[%0d]: got %h want %h", i, rd_mem(32'h2000 + 32'(4 * i)), 32'h9000_0000 + 32'(i * 32'h111));
      else passes++;
    end
    nrd = 0; nwr = 0;
    foreach (log_we[i]) if (log_we[i]) nwr++; else nrd++;
    checks++; if (nrd !== 9 || nwr !== 9) $display("FAIL len9_req_count: got %0d reads %0d writes want 9/9", nrd, nwr); else passes++;
    checks++; if (cyc_rise !== 6) $display("FAIL len9_phases: got %0d bus cycles want 6", cyc_rise); else passes++;
    checks++; if (phase_bad !== 0) $display("FAIL len9_issue_ack: got %0d unbalanced phases want 0", phase_bad); else passes++;
    checks++; if (done_cnt - d0 !== 1) $display("FAIL len9_done_pulses: got %0d want 1", done_cnt - d0); else passes++;
    checks++; if (ERR_OUT !== 1'b0) $display("FAIL len9_err: got %b want 0", ERR_OUT); else passes++;
    checks++; if (gap_viol !== 0) $display("FAIL len9_idle_gap: got %0d want 0", gap_viol); else passes++;
    stall_en = 1'b0; lat_max = 0;
  endtask

  task automatic test_wrap();
    logic [31:0] exp_adr [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    logic [31:0] src [3] = '{32'h0BAD_F00D, 32'h1357_9BDF, 32'h2468_ACE0};
    int d0;
    bit ok;
    clear_logs(); lat_max = 1;
    for (int i = 0; i < 3; i++) begin
      mem[exp_adr[i]] = src[i];
      mem[32'h10 + 32'(4 * i)] = 32'h0;
    end
    d0 = done_cnt;
    send_cmd(32'hFFFF_FFF8, 32'h10, 3);
    wait_done(d0, ok);
    checks++; if (ok !== 1'b1) $display("FAIL wrap_done_timeout: no DONE seen"); else passes++;
    for (int i = 0; i < 3 && i < log_adr.size(); i++) begin
      checks++; if (log_adr[i] !== exp_adr[i]) $display("FAIL wrap_adr[%0d]: got %h want %h", i, log_adr[i], exp_adr[i]); else passes++;
    end
    for (int i = 0; i < 3; i++) begin
      checks++; if (rd_mem(32'h10 + 32'(4 * i)) !== src[i]) $display("FAIL wrap_data[%0d]: got %h want %h", i, rd_mem(32'h10 + 32'(4 * i)), src[i]); else passes++;
    end
    checks++; if (ERR_OUT !== 1'b0) $display("FAIL wrap_err: got %b want 0", ERR_OUT); else passes++;
    lat_max = 0;
  endtask

  task automatic test_cti();
    int d0;
    bit ok;
    clear_logs();
    for (int i = 0; i < 4; i++) mem[32'h600 + 32'(4 * i)] = 32'h6000 + 32'(i);
    d0 = done_cnt;
    send_cmd(32'h600, 32'h700, 4);
    wait_done(d0, ok);
    checks++; if (ok !== 1'b1) $display("FAIL cti_done_timeout: no DONE seen"); else passes++;
    checks++; if (log_cti.size() !== 8) $display("FAIL cti_req_count: got %0d want 8", log_cti.size()); else passes++;
    for (int i = 0; i < 8 && i < log_cti.size(); i++) begin
      checks++; if (log_cti[i] !== exp_cti(i % 4, 4)) $display("FAIL cti_seq[%0d]: got %b want %b", i, log_cti[i], exp_cti(i % 4, 4)); else passes++;
    end
  endtask

  task automatic test_error();
    int d0, nwr;
    bit ok;
    clear_logs();
    err_at = 1;
    err_stb = 1'b1;
    err_cyc_next = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem[32'h300 + 32'(4 * i)] = 32'h3000 + 32'(i);
      mem[32'h380 + 32'(4 * i)] = 32'h5555_5555;
    end
    d0 = done_cnt;
    send_cmd(32'h300, 32'h380, 4);
    wait_done(d0, ok);
    checks++; if (ok !== 1'b1) $display("FAIL err_done_timeout: no DONE seen"); else passes++;
    checks++; if (ERR_OUT !== 1'b1) $display("FAIL err_sticky: got %b want 1", ERR_OUT); else passes++;
    checks++; if (err_stb !== 1'b0) $display("FAIL err_stb_drop: STB during ERR got %b want 0", err_stb); else passes++;
    checks++; if (err_cyc_next !== 1'b0) $display("FAIL err_cyc_drop: CYC after ERR got %b want 0", err_cyc_next); else passes++;
    nwr = 0;
    foreach (log_we[i]) if (log_we[i]) nwr++;
    checks++; if (nwr !== 0) $display("FAIL err_no_writes: got %0d writes want 0", nwr); else passes++;
    checks++; if (rd_mem(32'h380) !== 32'h5555_5555) $display("FAIL err_dst_untouched: got %h want 55555555", rd_mem(32'h380)); else passes++;
    checks++; if (done_cnt - d0 !== 1) $display("FAIL err_done_pulses: got %0d want 1", done_cnt - d0); else passes++;
    err_at = -1;
  endtask

  task automatic test_len0();
    int d0;
    clear_logs();
    d0 = done_cnt;
    send_cmd(32'h800, 32'h900, 0);
    #2;
    checks++; if (DONE_OUT !== 1'b1) $display("FAIL len0_done_next_cycle: got %b want 1", DONE_OUT); else passes++;
    checks++; if (ERR_OUT !== 1'b0) $display("FAIL len0_err_cleared: got %b want 0", ERR_OUT); else passes++;
    repeat (5) @(negedge CLK);
    #2;
    checks++; if (done_cnt - d0 !== 1) $display("FAIL len0_done_pulses: got %0d want 1", done_cnt - d0); else passes++;
    checks++; if (cyc_ever !== 1'b0) $display("FAIL len0_no_cycle: CYC seen %b want 0", cyc_ever); else passes++;
    checks++; if (CMD_READY_OUT !== 1'b1) $display("FAIL len0_ready: got %b want 1", CMD_READY_OUT); else passes++;
  endtask

  task automatic test_reset_mid_write();
    int n, d0;
    clear_logs(); stall_en = 1'b1; lat_max = 2;
    for (int i = 0; i < 8; i++) mem[32'h4000 + 32'(4 * i)] = 32'h4000_0000 + 32'(i);
    send_cmd(32'h4000, 32'h5000, 8);
    n = 0;
    while (!(WB_CYC_OUT && WB_WE_OUT) && n < 500) begin
      @(negedge CLK);
      #2;
      n++;
    end
    checks++; if (!(WB_CYC_OUT && WB_WE_OUT)) $display("FAIL rstw_reach_write: write phase not seen within %0d cycles", n); else passes++;
    #1;
    RST_ASYNC_N = 1'b0;
    d0 = done_cnt;
    #1;
    checks++; if ({WB_CYC_OUT, WB_STB_OUT, WB_WE_OUT} !== 3'b000) $display("FAIL rstw_cyc_stb_we: got %b want 000", {WB_CYC_OUT, WB_STB_OUT, WB_WE_OUT}); else passes++;
    checks++; if (WB_ADR_OUT !== 32'h0 || WB_DAT_WR_OUT !== 32'h0) $display("FAIL rstw_adr_dat: got %h/%h want 0/0", WB_ADR_OUT, WB_DAT_WR_OUT); else passes++;
    checks++; if (CMD_READY_OUT !== 1'b1 || DONE_OUT !== 1'b0 || ERR_OUT !== 1'b0) $display("FAIL rstw_ctrl: ready/done/err got %b%b%b want 100", CMD_READY_OUT, DONE_OUT, ERR_OUT); else passes++;
    checks++; if (WB_CTI_OUT !== 3'b000) $display("FAIL rstw_cti: got %b want 000", WB_CTI_OUT); else passes++;
    repeat (2) @(negedge CLK);
    RST_ASYNC_N = 1'b1;
    repeat (10) @(negedge CLK);
    #2;
    checks++; if (done_cnt !== d0) $display("FAIL rstw_no_done: got %0d pulses want 0", done_cnt - d0); else passes++;
    checks++; if (CMD_READY_OUT !== 1'b1 || WB_CYC_OUT !== 1'b0) $display("FAIL rstw_idle: ready/cyc got %b%b want 10", CMD_READY_OUT, WB_CYC_OUT); else passes++;
    stall_en = 1'b0; lat_max = 0;
  endtask

  initial begin
    test_reset();
    test_len3();
    test_len9();
    test_wrap();
    test_cti();
    test_error();
    test_len0();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

endmodule
